// File: rtl/lfsr_range_gen.sv
// Free-running Fibonacci LFSR that hands out bounded random numbers by rejection sampling.
// Optional macro LFSR_RANGE_PARALLEL_EN: sample the whole LFSR state in one cycle instead of bit-serially.
module lfsr_range_gen #(
    parameter int unsigned      WIDTH       = 6,
    parameter logic [WIDTH-1:0] TAPS        = 6'b110000,
    parameter int unsigned      MAX_RETRY   = 15,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(40)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_seed,
    input  logic             i_req,
    input  logic [WIDTH-1:0] i_limit,
    output logic [WIDTH-1:0] o_random,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_fallback,
    output logic [WIDTH-1:0] o_state
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2
    } fsm_t;

    fsm_t             fsm, fsm_nxt;
    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] seed_safe;
    logic [WIDTH-1:0] limit_q, limit_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [RW-1:0]    retry_cnt, retry_nxt;
    logic [WIDTH-1:0] random_nxt;
    logic             valid_nxt;
    logic             fallback_nxt;
    logic             accept;
    logic             start;

`ifndef LFSR_RANGE_PARALLEL_EN
    localparam int CW = $clog2(WIDTH);
    logic [CW-1:0] bit_cnt, bit_nxt;
`endif

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    assign seed_safe = (i_seed == '0) ? WIDTH'(1) : i_seed;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            state <= seed_safe;
        else if (state == '0)
            state <= seed_safe;
        else
            state <= {state[WIDTH-2:0], ^(state & TAPS)};
    end

    assign accept = (limit_q == '0) || (acc < limit_q);

    always_comb begin
        fsm_nxt      = fsm;
        limit_nxt    = limit_q;
        acc_nxt      = acc;
        retry_nxt    = retry_cnt;
        random_nxt   = o_random;
        valid_nxt    = 1'b0;
        fallback_nxt = 1'b0;
        start        = 1'b0;
`ifndef LFSR_RANGE_PARALLEL_EN
        bit_nxt      = bit_cnt;
`endif
        case (fsm)
            IDLE: start = i_req;
            COLLECT: begin
`ifdef LFSR_RANGE_PARALLEL_EN
                acc_nxt = state;
                fsm_nxt = CHECK;
`else
                acc_nxt = {state[0], acc[WIDTH-1:1]};
                if (bit_cnt == CW'(WIDTH - 1))
                    fsm_nxt = CHECK;
                else
                    bit_nxt = bit_cnt + 1'b1;
`endif
            end
            CHECK: begin
                if (accept) begin
                    random_nxt = acc;
                    valid_nxt  = 1'b1;
                    fsm_nxt    = IDLE;
                    start      = i_req;
                end else if (retry_cnt < RW'(MAX_RETRY)) begin
                    retry_nxt = retry_cnt + 1'b1;
                    fsm_nxt   = COLLECT;
`ifndef LFSR_RANGE_PARALLEL_EN
                    bit_nxt   = '0;
`endif
                end else begin
                    random_nxt   = '0;
                    valid_nxt    = 1'b1;
                    fallback_nxt = 1'b1;
                    fsm_nxt      = IDLE;
                    start        = i_req;
                end
            end
            default: fsm_nxt = IDLE;
        endcase
        // A request on the completing edge starts the next request without an idle gap.
        if (start) begin
            limit_nxt = i_limit;
            retry_nxt = '0;
            fsm_nxt   = COLLECT;
`ifndef LFSR_RANGE_PARALLEL_EN
            bit_nxt   = '0;
`endif
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            fsm        <= IDLE;
            limit_q    <= '0;
            acc        <= '0;
            retry_cnt  <= '0;
            o_random   <= RESET_VALUE;
            o_valid    <= 1'b0;
            o_fallback <= 1'b0;
`ifndef LFSR_RANGE_PARALLEL_EN
            bit_cnt    <= '0;
`endif
        end else begin
            fsm        <= fsm_nxt;
            limit_q    <= limit_nxt;
            acc        <= acc_nxt;
            retry_cnt  <= retry_nxt;
            o_random   <= random_nxt;
            o_valid    <= valid_nxt;
            o_fallback <= fallback_nxt;
`ifndef LFSR_RANGE_PARALLEL_EN
            bit_cnt    <= bit_nxt;
`endif
        end
    end

    assign o_busy  = (fsm != IDLE);
    assign o_state = state;

endmodule

// File: tb/tb_lfsr_range_gen.sv
// Directed bench for lfsr_range_gen at WIDTH=6, TAPS=6'b110000; expected values derived by hand
// from the LFSR sequence 000001, 000010, 000100, 001000, 010000, 100001, 000011, ...
module tb_lfsr_range_gen;
    localparam int W = 6;
`ifdef LFSR_RANGE_PARALLEL_EN
    localparam int         LAT        = 2;
    localparam logic [5:0] FIRST_VAL  = 6'd2;
    localparam int         RETRY_EDGE = 2;
    localparam logic [5:0] RETRY_VAL  = 6'd2;
    localparam int         ABORT_WAIT = 0;
`else
    localparam int         LAT        = 7;
    localparam logic [5:0] FIRST_VAL  = 6'd48;
    localparam int         RETRY_EDGE = 14;
    localparam logic [5:0] RETRY_VAL  = 6'd20;
    localparam int         ABORT_WAIT = 2;
`endif

    logic         clk;
    logic         rst;
    logic [W-1:0] seed;
    logic         req;
    logic [W-1:0] limit;
    logic [W-1:0] random;
    logic         valid;
    logic         busy;
    logic         fallback;
    logic [W-1:0] state;

    int checks;
    int failures;

    lfsr_range_gen #(
        .WIDTH(6), .TAPS(6'b110000), .MAX_RETRY(15), .RESET_VALUE(6'd40)
    ) dut (
        .i_clock(clk), .i_reset(rst), .i_seed(seed), .i_req(req), .i_limit(limit),
        .o_random(random), .o_valid(valid), .o_busy(busy), .o_fallback(fallback), .o_state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    // Leaves the bench on a negedge with reset just released; the next posedge is "edge 0".
    task automatic apply_reset(input logic [W-1:0] s);
        @(negedge clk);
        seed = s; req = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int zero_hits;
        @(negedge clk);
        seed = 6'd1; req = 1'b0; limit = '0; rst = 1'b1;
        #1;
        checks++; if (random !== 6'd40) begin failures++; $display("FAIL reset_random got=%0d exp=40", random); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (fallback !== 1'b0) begin failures++; $display("FAIL reset_fallback got=%0b exp=0", fallback); end
        checks++; if (state !== 6'b000001) begin failures++; $display("FAIL reset_state got=%b exp=000001", state); end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (state !== 6'b100001) begin failures++; $display("FAIL state_after5 got=%b exp=100001", state); end
        seed = 6'd0; rst = 1'b1;
        #1;
        checks++; if (state !== 6'b000001) begin failures++; $display("FAIL reset_seed0_state got=%b exp=000001", state); end
        @(negedge clk);
        rst = 1'b0;
        zero_hits = 0;
        repeat (200) begin
            @(negedge clk);
            if (state == '0) zero_hits++;
        end
        checks++; if (zero_hits !== 0) begin failures++; $display("FAIL lfsr_zero_hits got=%0d exp=0", zero_hits); end
    endtask

    task automatic test_single();
        int busy_cycles, vld_edge, vld_cnt;
        logic [W-1:0] got;
        logic fb;
        apply_reset(6'd1);
        limit = '0; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        busy_cycles = busy ? 1 : 0;
        vld_edge = -1; vld_cnt = 0; got = '0; fb = 1'b0;
        for (int k = 1; k <= LAT + 4; k++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (valid) begin
                vld_cnt++;
                if (vld_edge < 0) begin vld_edge = k; got = random; fb = fallback; end
            end
        end
        checks++; if (busy_cycles !== LAT) begin failures++; $display("FAIL single_busy_cycles got=%0d exp=%0d", busy_cycles, LAT); end
        checks++; if (vld_cnt !== 1) begin failures++; $display("FAIL single_valid_count got=%0d exp=1", vld_cnt); end
        checks++; if (vld_edge !== LAT) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", vld_edge, LAT); end
        checks++; if (got !== FIRST_VAL) begin failures++; $display("FAIL single_value got=%0d exp=%0d", got, FIRST_VAL); end
        checks++; if (fb !== 1'b0) begin failures++; $display("FAIL single_fallback got=%0b exp=0", fb); end
    endtask

    // 48 is rejected against limit 40; the retry yields 20. The limit change after edge 0 must not apply.
    task automatic test_retry();
        int vld_edge;
        logic [W-1:0] got;
        logic fb;
        apply_reset(6'd1);
        limit = 6'd40; req = 1'b1;
        @(negedge clk);
        req = 1'b0; limit = '0;
        vld_edge = -1; got = '0; fb = 1'b0;
        for (int k = 1; k <= RETRY_EDGE + 5; k++) begin
            @(negedge clk);
            if (valid && vld_edge < 0) begin vld_edge = k; got = random; fb = fallback; end
        end
        checks++; if (vld_edge !== RETRY_EDGE) begin failures++; $display("FAIL retry_latency got=%0d exp=%0d", vld_edge, RETRY_EDGE); end
        checks++; if (got !== RETRY_VAL) begin failures++; $display("FAIL retry_value got=%0d exp=%0d", got, RETRY_VAL); end
        checks++; if (fb !== 1'b0) begin failures++; $display("FAIL retry_fallback got=%0b exp=0", fb); end
    endtask

    // Limit 1 only admits 0, which six consecutive m-sequence bits never form: 16 attempts then fallback.
    task automatic test_fallback();
        int vld_edge;
        logic [W-1:0] got;
        logic fb;
        apply_reset(6'd1);
        limit = 6'd1; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        vld_edge = -1; got = 6'h3f; fb = 1'b0;
        for (int k = 1; k <= 16 * LAT + 5; k++) begin
            @(negedge clk);
            if (valid && vld_edge < 0) begin vld_edge = k; got = random; fb = fallback; end
        end
        checks++; if (vld_edge !== 16 * LAT) begin failures++; $display("FAIL fallback_latency got=%0d exp=%0d", vld_edge, 16 * LAT); end
        checks++; if (got !== 6'd0) begin failures++; $display("FAIL fallback_value got=%0d exp=0", got); end
        checks++; if (fb !== 1'b1) begin failures++; $display("FAIL fallback_flag got=%0b exp=1", fb); end
        repeat (5) @(negedge clk);
        checks++; if (random !== 6'd0) begin failures++; $display("FAIL fallback_hold got=%0d exp=0", random); end
        checks++; if (valid !== 1'b0 || fallback !== 1'b0) begin failures++; $display("FAIL fallback_pulse_width got=%0b%0b exp=00", valid, fallback); end
    endtask

    task automatic test_back_to_back();
        int n, bad;
        apply_reset(6'd1);
        limit = '0; req = 1'b1;
        n = 0; bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (valid) begin
                n++;
                if (k == 0 || (k % LAT) != 0 || fallback) bad++;
            end
        end
        req = 1'b0;
        checks++; if (n !== 19 / LAT) begin failures++; $display("FAIL b2b_pulses got=%0d exp=%0d", n, 19 / LAT); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL b2b_pulse_edges got=%0d exp=0", bad); end
        for (int k = 0; k < 60 && busy; k++) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0b exp=0", busy); end
    endtask

    task automatic test_stream();
        int n, bad, cyc;
        apply_reset(6'd1);
        limit = 6'd40; req = 1'b1;
        n = 0; bad = 0; cyc = 0;
        while (n < 200 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (valid) begin
                n++;
                if (fallback ? (random != 6'd0) : (random >= 6'd40)) bad++;
            end
        end
        req = 1'b0;
        checks++; if (n !== 200) begin failures++; $display("FAIL stream_count got=%0d exp=200", n); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL stream_out_of_range got=%0d exp=0", bad); end
        for (int k = 0; k < 200 && busy; k++) @(negedge clk);
    endtask

    task automatic test_abort();
        int n;
        apply_reset(6'd1);
        limit = '0; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        for (int k = 1; k <= LAT; k++) @(negedge clk);
        checks++; if (random !== FIRST_VAL) begin failures++; $display("FAIL abort_pre_value got=%0d exp=%0d", random, FIRST_VAL); end
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (ABORT_WAIT) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_pre_busy got=%0b exp=1", busy); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0b exp=0", busy); end
        checks++; if (random !== 6'd40) begin failures++; $display("FAIL abort_random got=%0d exp=40", random); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%0b exp=0", valid); end
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (valid || busy) n++;
        end
        checks++; if (n !== 0) begin failures++; $display("FAIL abort_quiet got=%0d exp=0", n); end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; seed = 6'd1; req = 1'b0; limit = '0;
        test_reset();
        test_single();
        test_retry();
        test_fallback();
        test_back_to_back();
        test_stream();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
